// File: rtl/adc_frame_buffer.sv
// Ping-pong capture buffer between a multi-channel parallel ADC and the FFT stream input.
// One bank fills from the ADC while the other streams channel frames out over valid/ready.
module adc_frame_buffer #(
  parameter int DATA_W     = 16,
  parameter int CHANNELS   = 2,
  parameter int FRAME_LEN  = 16,
  parameter int DIV        = 4,
  parameter int CONTINUOUS = 0
) (
  input  logic                         CLK,
  input  logic                         RST,
  input  logic                         START,
  input  logic [CHANNELS*DATA_W-1:0]   DATA_IN,
  input  logic                         IN_VALID,
  output logic                         SAMPLE_REQ,
  output logic                         EVT_FRAME_STARTED,
  output logic [2*DATA_W-1:0]          OUT_DATA,
  output logic [$clog2(CHANNELS):0]    OUT_CHAN,
  output logic                         OUT_VALID,
  input  logic                         OUT_READY,
  output logic                         OUT_LAST,
  output logic                         OVERFLOW,
  output logic                         BUSY
);

  localparam int IW     = $clog2(FRAME_LEN);
  localparam int CW     = $clog2(CHANNELS) + 1;
  localparam int DW     = $clog2(DIV);
  localparam bit CONT_B = (CONTINUOUS != 0);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  state_t                     state_r, state_next_s;
  logic [CHANNELS*DATA_W-1:0] mem_r [2*FRAME_LEN];
  logic                       wr_bank_r;
  logic [IW-1:0]              wr_idx_r, wr_idx_next_s;
  logic [DW-1:0]              div_cnt_r, div_cnt_next_s;
  logic                       rd_busy_r, rd_busy_next_s;
  logic                       wr_en_s, swap_s, release_s, overflow_set_s, frame_start_s;
  logic                       sample_req_r, evt_r, overflow_r, busy_r;

  logic [IW-1:0]              rd_idx_r;
  logic [CW-1:0]              rd_chan_r;
  logic                       issue_active_r;
  logic [CHANNELS*DATA_W-1:0] rd_word_s;
  logic                       p1_valid_r, p1_last_r;
  logic [DATA_W-1:0]          p1_data_r;
  logic [CW-1:0]              p1_chan_r;
  logic                       out_valid_r, out_last_r;
  logic [DATA_W-1:0]          out_data_r;
  logic [CW-1:0]              out_chan_r;
  logic                       xfer_s, load_out_s, issue_s;

  // The read bank is always the one not being written; the final beat of the last channel frees it.
  assign rd_word_s  = mem_r[{~wr_bank_r, rd_idx_r}];
  assign xfer_s     = out_valid_r & OUT_READY;
  assign release_s  = xfer_s & out_last_r & (out_chan_r == CW'(CHANNELS - 1));
  assign load_out_s = p1_valid_r & (~out_valid_r | OUT_READY);
  assign issue_s    = issue_active_r & (~p1_valid_r | load_out_s);

  // Write FSM next-state, bank swap and overflow decisions
  always_comb begin
    state_next_s   = state_r;
    wr_idx_next_s  = wr_idx_r;
    div_cnt_next_s = div_cnt_r;
    rd_busy_next_s = rd_busy_r & ~release_s;
    wr_en_s        = 1'b0;
    swap_s         = 1'b0;
    overflow_set_s = 1'b0;
    frame_start_s  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (START) begin
          state_next_s   = ST_FILL;
          div_cnt_next_s = '0;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_FILL: begin
        div_cnt_next_s = (div_cnt_r == DW'(DIV - 1)) ? '0 : div_cnt_r + DW'(1);
        if (IN_VALID) begin
          wr_en_s       = 1'b1;
          wr_idx_next_s = wr_idx_r + IW'(1);
          frame_start_s = (wr_idx_r == '0);
          if (wr_idx_r == IW'(FRAME_LEN - 1)) begin
            if (!rd_busy_r || release_s) begin
              swap_s       = 1'b1;
              state_next_s = CONT_B ? ST_FILL : ST_IDLE;
            end else begin
              state_next_s = ST_HOLD;
            end
          end else begin
            state_next_s = ST_FILL;
          end
        end else begin
          state_next_s = ST_FILL;
        end
      end
      ST_HOLD: begin
        overflow_set_s = IN_VALID;
        if (release_s) begin
          swap_s         = 1'b1;
          state_next_s   = CONT_B ? ST_FILL : ST_IDLE;
          div_cnt_next_s = '0;
        end else begin
          state_next_s = ST_HOLD;
        end
      end
      default: begin
        state_next_s = ST_IDLE;
      end
    endcase
    if (swap_s) begin
      rd_busy_next_s = 1'b1;
    end else begin
      rd_busy_next_s = rd_busy_next_s;
    end
  end

  // Write-side state, counters and registered status outputs
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_r      <= ST_IDLE;
      wr_bank_r    <= 1'b0;
      wr_idx_r     <= '0;
      div_cnt_r    <= '0;
      rd_busy_r    <= 1'b0;
      sample_req_r <= 1'b0;
      evt_r        <= 1'b0;
      overflow_r   <= 1'b0;
      busy_r       <= 1'b0;
    end else begin
      state_r      <= state_next_s;
      wr_bank_r    <= wr_bank_r ^ swap_s;
      wr_idx_r     <= wr_idx_next_s;
      div_cnt_r    <= div_cnt_next_s;
      rd_busy_r    <= rd_busy_next_s;
      sample_req_r <= (state_next_s == ST_FILL) && (div_cnt_next_s == DW'(DIV - 1));
      evt_r        <= frame_start_s;
      overflow_r   <= overflow_r | overflow_set_s;
      busy_r       <= (state_next_s != ST_IDLE) || (wr_idx_next_s != '0) || rd_busy_next_s;
    end
  end

  // Sample storage: both banks in one array, bank select in the address MSB
  always_ff @(posedge CLK) begin
    if (wr_en_s) begin
      mem_r[{wr_bank_r, wr_idx_r}] <= DATA_IN;
    end
  end

  // Read address sequencing, registered RAM read stage and output register with prefetch
  always_ff @(posedge CLK) begin
    if (RST) begin
      issue_active_r <= 1'b0;
      rd_idx_r       <= '0;
      rd_chan_r      <= '0;
      p1_valid_r     <= 1'b0;
      p1_data_r      <= '0;
      p1_chan_r      <= '0;
      p1_last_r      <= 1'b0;
      out_valid_r    <= 1'b0;
      out_data_r     <= '0;
      out_chan_r     <= '0;
      out_last_r     <= 1'b0;
    end else begin
      if (swap_s) begin
        issue_active_r <= 1'b1;
        rd_idx_r       <= '0;
        rd_chan_r      <= '0;
      end else if (issue_s) begin
        rd_idx_r <= rd_idx_r + IW'(1);
        if (rd_idx_r == IW'(FRAME_LEN - 1)) begin
          rd_chan_r <= rd_chan_r + CW'(1);
          if (rd_chan_r == CW'(CHANNELS - 1)) begin
            issue_active_r <= 1'b0;
          end
        end
      end
      if (issue_s) begin
        p1_valid_r <= 1'b1;
        p1_data_r  <= rd_word_s[int'(rd_chan_r)*DATA_W +: DATA_W];
        p1_chan_r  <= rd_chan_r;
        p1_last_r  <= (rd_idx_r == IW'(FRAME_LEN - 1));
      end else if (load_out_s) begin
        p1_valid_r <= 1'b0;
      end
      if (load_out_s) begin
        out_valid_r <= 1'b1;
        out_data_r  <= p1_data_r;
        out_chan_r  <= p1_chan_r;
        out_last_r  <= p1_last_r;
      end else if (xfer_s) begin
        out_valid_r <= 1'b0;
      end
    end
  end

  assign SAMPLE_REQ        = sample_req_r;
  assign EVT_FRAME_STARTED = evt_r;
  assign OUT_DATA          = {{DATA_W{1'b0}}, out_data_r};
  assign OUT_CHAN          = out_chan_r;
  assign OUT_VALID         = out_valid_r;
  assign OUT_LAST          = out_last_r;
  assign OVERFLOW          = overflow_r;
  assign BUSY              = busy_r;

endmodule
